block_memory_model: RTL and testbench
=====================================

Name: block_memory_model

Overview:
- Main-memory stage directly downstream of the cache controller.
- Consumes fetch requests (block base address) and write-back requests (dirty victim block plus address) from the controller's memory side.
- Returns whole cache blocks after a programmable latency.
- Single outstanding operation; synthesizable block-granular storage array used as the memory endpoint in the cache testbench and FPGA builds.

Parameters:
- BLOCK_SIZE, 32, bytes per cache block; data buses are 8*BLOCK_SIZE bits wide.
- ADDRESS_WIDTH, 32, byte address width.
- MEM_BLOCKS, 256, number of blocks stored; power of two, at least 2.
- READ_LATENCY, 4, cycles from fetch accept to fetchValid; at least 1.
- WRITE_LATENCY, 4, cycles from write-back accept to writeBackDone; at least 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- fetchRequest  input  1  controller requests a block fetch
- fetchAddress  input  ADDRESS_WIDTH  byte address of the requested block
- fetchReady  output  1  fetch request can be accepted this cycle
- fetchedData  output  8*BLOCK_SIZE  returned block; byte 0 in bits [7:0]
- fetchValid  output  1  one-cycle pulse: fetchedData is valid
- writeBackRequest  input  1  controller requests a block write-back
- writeBackAddress  input  ADDRESS_WIDTH  byte address of the victim block
- writeBackData  input  8*BLOCK_SIZE  victim block data
- writeBackReady  output  1  write-back request can be accepted this cycle
- writeBackDone  output  1  one-cycle pulse: write committed to the array
- busy  output  1  an operation is in flight

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - Internal state goes to IDLE.
  - fetchValid=0, writeBackDone=0, busy=0.
  - fetchedData=0.
  - Latency counter=0.
  - Array contents are not reset.
- Address decode:
  - offset bits: log2(BLOCK_SIZE) LSBs; ignored.
  - index: next log2(MEM_BLOCKS) bits.
  - Higher bits are ignored, so addresses alias modulo MEM_BLOCKS*BLOCK_SIZE.
- Ready rules:
  - fetchReady = writeBackReady = (state==IDLE) && !reset. Both are combinational from state only.
  - Accept happens on a cycle with request && ready.
  - Address and data are captured into internal registers at accept; input buses are don't-care afterwards.
- Arbitration: if both requests are high in IDLE, the write-back is accepted and the fetch is left pending.
  - The controller holds fetchRequest; the fetch is accepted on the first IDLE cycle after writeBackDone.
  - A fetch to the same block therefore returns the written-back data.
- State machine, states IDLE, WRITE_WAIT, READ_WAIT:
  - IDLE -> WRITE_WAIT on write-back accept; counter loads WRITE_LATENCY-1.
  - IDLE -> READ_WAIT on fetch accept (when no write-back is requested); counter loads READ_LATENCY-1.
  - WRITE_WAIT: counter decrements each cycle. When counter==0, on that edge:
    - array[index] <= captured data;
    - writeBackDone pulses on the following cycle;
    - state returns to IDLE.
  - READ_WAIT: counter decrements each cycle. When counter==0, on that edge:
    - fetchedData <= array[index];
    - fetchValid pulses on the following cycle;
    - state returns to IDLE.
- Latency:
  - Accept at edge N gives fetchValid/writeBackDone high in the cycle after edge N+LATENCY.
  - The module is ready again in that same cycle, so back-to-back requests have a throughput of one per LATENCY+1 cycles.
- fetchedData holds its value until the next fetch completes.
- busy = (state != IDLE).
- Reset mid-operation:
  - The in-flight operation is aborted and no pulse is emitted.
  - An aborted write-back leaves the array unchanged.
  - An aborted fetch leaves fetchedData=0.
- Requests deasserted while not ready have no effect; nothing is queued internally.

Optional Feature:
- Macro: BLOCK_MEMORY_ADDR_CHECK_EN.
- When defined: an extra output port addrError (1 bit, reset 0) is present.
  - It pulses for one cycle, in the cycle after an accept, if the accepted address has nonzero offset bits or nonzero bits above the index field.
  - The operation still completes normally using the decoded index.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- Write-back then fetch: WRITE_LATENCY=4. Write-back 0x0000_0040 with data pattern A5 repeated, then fetch 0x0000_0040.
  -> writeBackDone 5 cycles after accept; fetchValid 5 cycles after fetch accept; fetchedData = A5 pattern.
- Simultaneous requests: fetch and write-back both to 0x80 in the same IDLE cycle.
  -> write-back accepted first, fetchReady=0 while busy; fetch accepted after writeBackDone; returns the new data.
- Aliasing: write-back to 0x0000_2000 (index 0 with MEM_BLOCKS=256, BLOCK_SIZE=32), then fetch 0x0000_0000.
  -> same data returned. With BLOCK_MEMORY_ADDR_CHECK_EN, addrError=1 on the write-back only.
- Reset mid-write: assert reset 2 cycles into WRITE_WAIT, then fetch the same block.
  -> no writeBackDone pulse; old contents returned; all outputs 0 during reset.
- Back-to-back fetches to blocks 1, 2, 3 with requests held high.
  -> three fetchValid pulses spaced READ_LATENCY+1 cycles apart, carrying the correct blocks in order.
- Offset ignored: fetch 0x0000_0047.
  -> returns block index 2 data; addrError=1 only when the macro is defined.

Source files
------------

// File: rtl/block_memory_model.sv
// Block-granular main-memory endpoint behind the cache controller: one outstanding
// fetch or write-back, fixed programmable latency. Optional BLOCK_MEMORY_ADDR_CHECK_EN adds addrError.
module block_memory_model #(
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_BLOCKS    = 256,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetchRequest,
    input  logic [ADDRESS_WIDTH-1:0]  fetchAddress,
    output logic                      fetchReady,
    output logic [8*BLOCK_SIZE-1:0]   fetchedData,
    output logic                      fetchValid,
    input  logic                      writeBackRequest,
    input  logic [ADDRESS_WIDTH-1:0]  writeBackAddress,
    input  logic [8*BLOCK_SIZE-1:0]   writeBackData,
    output logic                      writeBackReady,
    output logic                      writeBackDone,
    output logic                      busy
`ifdef BLOCK_MEMORY_ADDR_CHECK_EN
    ,
    output logic                      addrError
`endif
);

    localparam int DATA_WIDTH  = 8 * BLOCK_SIZE;
    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
    localparam int INDEX_BITS  = $clog2(MEM_BLOCKS);
    localparam int MAX_LATENCY = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int COUNT_WIDTH = (MAX_LATENCY > 1) ? $clog2(MAX_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_WAIT,
        READ_WAIT
    } stateType;

    stateType                 state;
    logic [COUNT_WIDTH-1:0]   latencyCount;
    logic [INDEX_BITS-1:0]    opIndex;
    logic [INDEX_BITS-1:0]    fetchIndex;
    logic [INDEX_BITS-1:0]    writeBackIndex;
    logic [DATA_WIDTH-1:0]    writeBackBuffer;
    logic [DATA_WIDTH-1:0]    storage [MEM_BLOCKS];

    assign fetchIndex     = fetchAddress[OFFSET_BITS +: INDEX_BITS];
    assign writeBackIndex = writeBackAddress[OFFSET_BITS +: INDEX_BITS];

    assign fetchReady     = (state == IDLE) && !reset;
    assign writeBackReady = (state == IDLE) && !reset;

`ifdef BLOCK_MEMORY_ADDR_CHECK_EN
    logic fetchMisaligned;
    logic writeBackMisaligned;

    // An address is clean only if it equals its own block base within the mapped window.
    assign fetchMisaligned     = fetchAddress != (ADDRESS_WIDTH'(fetchIndex) << OFFSET_BITS);
    assign writeBackMisaligned = writeBackAddress != (ADDRESS_WIDTH'(writeBackIndex) << OFFSET_BITS);
`else
    logic unusedAddressBits;
    assign unusedAddressBits = ^{fetchAddress, writeBackAddress};
`endif

    // Array has no reset; an aborted write never reaches here because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (state == WRITE_WAIT && latencyCount == '0) begin
            storage[opIndex] <= writeBackBuffer;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            latencyCount    <= '0;
            opIndex         <= '0;
            writeBackBuffer <= '0;
            fetchedData     <= '0;
            fetchValid      <= 1'b0;
            writeBackDone   <= 1'b0;
            busy            <= 1'b0;
`ifdef BLOCK_MEMORY_ADDR_CHECK_EN
            addrError       <= 1'b0;
`endif
        end else begin
            fetchValid    <= 1'b0;
            writeBackDone <= 1'b0;
`ifdef BLOCK_MEMORY_ADDR_CHECK_EN
            addrError     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Write-back wins a tie; the held fetch is taken once we return to IDLE.
                    if (writeBackRequest) begin
                        state           <= WRITE_WAIT;
                        latencyCount    <= COUNT_WIDTH'(WRITE_LATENCY - 1);
                        opIndex         <= writeBackIndex;
                        writeBackBuffer <= writeBackData;
                        busy            <= 1'b1;
`ifdef BLOCK_MEMORY_ADDR_CHECK_EN
                        addrError       <= writeBackMisaligned;
`endif
                    end else if (fetchRequest) begin
                        state        <= READ_WAIT;
                        latencyCount <= COUNT_WIDTH'(READ_LATENCY - 1);
                        opIndex      <= fetchIndex;
                        busy         <= 1'b1;
`ifdef BLOCK_MEMORY_ADDR_CHECK_EN
                        addrError    <= fetchMisaligned;
`endif
                    end
                end
                WRITE_WAIT: begin
                    if (latencyCount == '0) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        writeBackDone <= 1'b1;
                    end else begin
                        latencyCount <= latencyCount - 1'b1;
                    end
                end
                READ_WAIT: begin
                    if (latencyCount == '0) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        fetchedData <= storage[opIndex];
                        fetchValid  <= 1'b1;
                    end else begin
                        latencyCount <= latencyCount - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_memory_model.sv
// Directed + randomized bench for block_memory_model against a block-array reference model.
// Build with BLOCK_MEMORY_ADDR_CHECK_EN defined to also check addrError.
module tb_block_memory_model;

    localparam int BLOCK_SIZE    = 32;
    localparam int ADDRESS_WIDTH = 32;
    localparam int MEM_BLOCKS    = 256;
    localparam int READ_LATENCY  = 4;
    localparam int WRITE_LATENCY = 4;
    localparam int DW            = 8 * BLOCK_SIZE;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     fetchRequest = 1'b0;
    logic [ADDRESS_WIDTH-1:0] fetchAddress = '0;
    logic                     fetchReady;
    logic [DW-1:0]            fetchedData;
    logic                     fetchValid;
    logic                     writeBackRequest = 1'b0;
    logic [ADDRESS_WIDTH-1:0] writeBackAddress = '0;
    logic [DW-1:0]            writeBackData = '0;
    logic                     writeBackReady;
    logic                     writeBackDone;
    logic                     busy;
`ifdef BLOCK_MEMORY_ADDR_CHECK_EN
    logic                     addrError;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] refMem [MEM_BLOCKS];

    always #5 clk = ~clk;

    block_memory_model #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .MEM_BLOCKS(MEM_BLOCKS),
        .READ_LATENCY(READ_LATENCY),
        .WRITE_LATENCY(WRITE_LATENCY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetchRequest(fetchRequest),
        .fetchAddress(fetchAddress),
        .fetchReady(fetchReady),
        .fetchedData(fetchedData),
        .fetchValid(fetchValid),
        .writeBackRequest(writeBackRequest),
        .writeBackAddress(writeBackAddress),
        .writeBackData(writeBackData),
        .writeBackReady(writeBackReady),
        .writeBackDone(writeBackDone),
        .busy(busy)
`ifdef BLOCK_MEMORY_ADDR_CHECK_EN
        ,
        .addrError(addrError)
`endif
    );

    task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] randBlock();
        logic [DW-1:0] b;
        for (int i = 0; i < DW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic int unsigned blockOf(input logic [ADDRESS_WIDTH-1:0] addr);
        return (addr / BLOCK_SIZE) % MEM_BLOCKS;
    endfunction

    function automatic logic badAddress(input logic [ADDRESS_WIDTH-1:0] addr);
        return ((addr % BLOCK_SIZE) != 0) || (addr >= MEM_BLOCKS * BLOCK_SIZE);
    endfunction

    task automatic checkIdleOutputs(input string tag);
        check({tag, ":fetchValid"}, fetchValid, 0);
        check({tag, ":wbDone"}, writeBackDone, 0);
        check({tag, ":busy"}, busy, 0);
        check({tag, ":fetchedData"}, fetchedData, 0);
        check({tag, ":fetchReady"}, fetchReady, 0);
        check({tag, ":wbReady"}, writeBackReady, 0);
`ifdef BLOCK_MEMORY_ADDR_CHECK_EN
        check({tag, ":addrError"}, addrError, 0);
`endif
    endtask

    task automatic wbOp(input logic [ADDRESS_WIDTH-1:0] addr, input logic [DW-1:0] data, input string tag);
        int lat;
        logic done;
        @(negedge clk);
        check({tag, ":wbReady"}, writeBackReady, 1);
        writeBackRequest = 1'b1;
        writeBackAddress = addr;
        writeBackData    = data;
        @(posedge clk);
        #1;
        writeBackRequest = 1'b0;
        writeBackAddress = $urandom;
        writeBackData    = randBlock();
        lat = 0;
        done = 1'b0;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
`ifdef BLOCK_MEMORY_ADDR_CHECK_EN
            if (lat == 1) check({tag, ":addrError"}, addrError, badAddress(addr));
            else check({tag, ":addrErrorLow"}, addrError, 0);
`endif
            if (writeBackDone) done = 1'b1;
            else begin
                check({tag, ":busy"}, busy, 1);
                check({tag, ":fetchReadyBusy"}, fetchReady, 0);
            end
        end
        check({tag, ":wbLatency"}, DW'(lat), DW'(WRITE_LATENCY + 1));
        check({tag, ":readyAgain"}, writeBackReady, 1);
        check({tag, ":busyClear"}, busy, 0);
        refMem[blockOf(addr)] = data;
        @(negedge clk);
        check({tag, ":wbDonePulse"}, writeBackDone, 0);
    endtask

    task automatic fetchOp(input logic [ADDRESS_WIDTH-1:0] addr, input string tag);
        int lat;
        logic done;
        logic [DW-1:0] expected;
        expected = refMem[blockOf(addr)];
        @(negedge clk);
        check({tag, ":fetchReady"}, fetchReady, 1);
        fetchRequest = 1'b1;
        fetchAddress = addr;
        @(posedge clk);
        #1;
        fetchRequest = 1'b0;
        fetchAddress = $urandom;
        lat = 0;
        done = 1'b0;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
`ifdef BLOCK_MEMORY_ADDR_CHECK_EN
            if (lat == 1) check({tag, ":addrError"}, addrError, badAddress(addr));
            else check({tag, ":addrErrorLow"}, addrError, 0);
`endif
            if (fetchValid) done = 1'b1;
            else check({tag, ":wbReadyBusy"}, writeBackReady, 0);
        end
        check({tag, ":rdLatency"}, DW'(lat), DW'(READ_LATENCY + 1));
        check({tag, ":data"}, fetchedData, expected);
        @(negedge clk);
        check({tag, ":fetchValidPulse"}, fetchValid, 0);
        check({tag, ":dataHold"}, fetchedData, expected);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] oldData;
        int lat;
        int issued;
        int got;
        int last;
        logic rdy;

        // Reset state
        repeat (2) @(negedge clk);
        checkIdleOutputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check("postReset:fetchReady", fetchReady, 1);

        for (int i = 0; i < 8; i++) wbOp(ADDRESS_WIDTH'(i * BLOCK_SIZE), randBlock(), "preload");

        // Write-back then fetch of the A5 pattern
        wbOp(32'h0000_0040, {BLOCK_SIZE{8'hA5}}, "wbA5");
        fetchOp(32'h0000_0040, "fetchA5");
        check("a5Pattern", fetchedData, {BLOCK_SIZE{8'hA5}});

        // Simultaneous requests: write-back first, held fetch sees the new data
        d = randBlock();
        @(negedge clk);
        fetchRequest = 1'b1;
        fetchAddress = 32'h80;
        writeBackRequest = 1'b1;
        writeBackAddress = 32'h80;
        writeBackData = d;
        @(posedge clk);
        #1;
        writeBackRequest = 1'b0;
        writeBackData = randBlock();
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (writeBackDone) break;
            check("simul:fetchReadyBusy", fetchReady, 0);
            check("simul:noEarlyFetch", fetchValid, 0);
        end
        check("simul:wbLatency", DW'(lat), DW'(WRITE_LATENCY + 1));
        check("simul:fetchReadyAtDone", fetchReady, 1);
        refMem[blockOf(32'h80)] = d;
        @(posedge clk);
        #1;
        fetchRequest = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (fetchValid) break;
        end
        check("simul:rdLatency", DW'(lat), DW'(READ_LATENCY + 1));
        check("simul:data", fetchedData, d);

        // Aliasing: 0x2000 maps to block 0
        wbOp(32'h0000_2000, randBlock(), "aliasWb");
        fetchOp(32'h0000_0000, "aliasFetch");

        // Reset two cycles into WRITE_WAIT aborts the write
        oldData = refMem[5];
        @(negedge clk);
        writeBackRequest = 1'b1;
        writeBackAddress = ADDRESS_WIDTH'(5 * BLOCK_SIZE);
        writeBackData = ~oldData;
        @(posedge clk);
        #1;
        writeBackRequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkIdleOutputs("midReset");
        repeat (2) @(negedge clk);
        check("midReset:noDone", writeBackDone, 0);
        reset = 1'b0;
        for (int i = 0; i < WRITE_LATENCY + 2; i++) begin
            @(negedge clk);
            check("afterReset:noDone", writeBackDone, 0);
            check("afterReset:idle", busy, 0);
        end
        fetchOp(ADDRESS_WIDTH'(5 * BLOCK_SIZE), "afterReset");
        check("afterReset:oldData", fetchedData, oldData);

        // Back-to-back fetches of blocks 1, 2, 3 with request held
        @(negedge clk);
        fetchRequest = 1'b1;
        fetchAddress = ADDRESS_WIDTH'(BLOCK_SIZE);
        issued = 0;
        got = 0;
        last = 0;
        rdy = fetchReady;
        for (int cyc = 1; cyc <= 60 && got < 3; cyc++) begin
            @(posedge clk);
            #1;
            if (rdy && issued < 3) begin
                issued++;
                if (issued < 3) fetchAddress = ADDRESS_WIDTH'((issued + 1) * BLOCK_SIZE);
                else fetchRequest = 1'b0;
            end
            @(negedge clk);
            rdy = fetchReady;
            if (fetchValid) begin
                check("b2b:data", fetchedData, refMem[got + 1]);
                if (got == 0) check("b2b:firstLatency", DW'(cyc), DW'(READ_LATENCY + 1));
                else check("b2b:spacing", DW'(cyc - last), DW'(READ_LATENCY + 1));
                last = cyc;
                got++;
            end
        end
        fetchRequest = 1'b0;
        check("b2b:count", DW'(got), DW'(3));

        // Offset bits ignored
        fetchOp(32'h0000_0047, "offset");

        // Randomized traffic over aliased / offset addresses
        for (int n = 0; n < 40; n++) begin
            logic [ADDRESS_WIDTH-1:0] a;
            a = ADDRESS_WIDTH'($urandom_range(0, 7) * BLOCK_SIZE);
            if ($urandom_range(0, 1) == 1) a = a | ADDRESS_WIDTH'($urandom_range(0, BLOCK_SIZE - 1));
            if ($urandom_range(0, 2) == 0) a = a | (ADDRESS_WIDTH'($urandom_range(1, 7)) << 13);
            if ($urandom_range(0, 1) == 1) wbOp(a, randBlock(), "randWb");
            else fetchOp(a, "randFetch");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
